// File: rtl/timer_pkg.sv
// timer_pkg: shared state encoding and mode constants for the timer channels.
package timer_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;
endpackage

// File: rtl/multi_timer_if.sv
// multi_timer_if: per-channel control and status bundle of the multi-channel timer.
interface multi_timer_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 4
);
  logic [NUM_CH*CNT_W-1:0] value;
  logic [NUM_CH-1:0]       start_timer;
  logic [NUM_CH-1:0]       stop_timer;
  logic [NUM_CH-1:0]       periodic;
  logic [NUM_CH-1:0]       pause;
  logic [NUM_CH-1:0]       expired;
  logic [NUM_CH-1:0]       expire_pulse;
  logic [NUM_CH-1:0]       busy;
  modport master (output value, start_timer, stop_timer, periodic, pause,
                  input expired, expire_pulse, busy);
  modport slave  (input value, start_timer, stop_timer, periodic, pause,
                  output expired, expire_pulse, busy);
endinterface

// File: rtl/timer_channel.sv
// timer_channel: one down-count timer FSM with one-shot/periodic modes, pause and stop.
module timer_channel
  import timer_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset_sync,
  input  logic             i_tick,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_periodic,
  input  logic             i_pause,
  input  logic [CNT_W-1:0] i_value,
  output logic             o_expired,
  output logic             o_expire_pulse,
  output logic             o_busy
);
  state_t             r_state, w_state;
  logic [CNT_W-1:0]   r_count, w_count, r_reload, w_reload;
  logic               r_mode, w_mode, r_expired, w_expired, r_pulse, w_pulse;
  logic               w_step, w_expire, w_keep;

  always_ff @(posedge clk or posedge reset_sync)
    if (reset_sync) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_reload  <= '0;
      r_mode    <= MODE_ONESHOT;
      r_expired <= 1'b0;
      r_pulse   <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_count   <= w_count;
      r_reload  <= w_reload;
      r_mode    <= w_mode;
      r_expired <= w_expired;
      r_pulse   <= w_pulse;
    end

  // A zero load expires without a tick and never reloads, so periodic+0 cannot storm.
  always_comb begin
    w_state   = r_state;
    w_count   = r_count;
    w_reload  = r_reload;
    w_mode    = r_mode;
    w_expired = r_expired;
    w_pulse   = 1'b0;
    w_step    = (r_state == RUN) && i_tick && !i_pause;
    w_expire  = (r_state == RUN) && ((r_count == '0) || (w_step && r_count == CNT_W'(1)));
    w_keep    = (r_mode == MODE_PERIODIC) && (r_count != '0);
    if (i_start) begin
      w_state   = RUN;
      w_count   = i_value;
      w_reload  = i_value;
      w_mode    = i_periodic ? MODE_PERIODIC : MODE_ONESHOT;
      w_expired = 1'b0;
    end else if (i_stop) begin
      w_state   = IDLE;
      w_expired = 1'b0;
    end else if (w_expire) begin
      w_state   = w_keep ? RUN : DONE;
      w_count   = w_keep ? r_reload : '0;
      w_expired = 1'b1;
      w_pulse   = 1'b1;
    end else if (w_step) begin
      w_count   = r_count - CNT_W'(1);
    end
  end

  assign o_expired      = r_expired;
  assign o_expire_pulse = r_pulse;
  assign o_busy         = (r_state == RUN);
endmodule

// File: rtl/multi_timer.sv
// multi_timer: NUM_CH independent down-count timers stepped by a shared clk_div rising edge.
module multi_timer
  import timer_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 4
) (
  input logic         clk,
  input logic         reset_sync,
  input logic         clk_div,
  multi_timer_if.slave bus
);
  logic r_div_q;
  logic w_tick;

  always_ff @(posedge clk or posedge reset_sync)
    if (reset_sync) r_div_q <= 1'b0;
    else r_div_q <= clk_div;

  assign w_tick = clk_div & ~r_div_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    timer_channel #(.CNT_W(CNT_W)) u_ch (
      .clk            (clk),
      .reset_sync     (reset_sync),
      .i_tick         (w_tick),
      .i_start        (bus.start_timer[g]),
      .i_stop         (bus.stop_timer[g]),
      .i_periodic     (bus.periodic[g]),
      .i_pause        (bus.pause[g]),
      .i_value        (bus.value[g*CNT_W +: CNT_W]),
      .o_expired      (bus.expired[g]),
      .o_expire_pulse (bus.expire_pulse[g]),
      .o_busy         (bus.busy[g])
    );
  end
endmodule
